// File: rtl/dp_sched_pkg.sv
// dp_sched_pkg: sequencer state encoding and default sizing for dp_share_sched.
package dp_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int unsigned DEF_OPW    = 14;
  localparam int unsigned DEF_RESW   = 8;
  localparam int unsigned SETTLE_MIN = 1;
  localparam int unsigned SETTLE_MAX = 15;
  localparam int unsigned CNT_W      = 4;

endpackage

// File: rtl/dp_share_sched_rr_arbiter.sv
// rr_arbiter: round-robin pick among req, search starting at ptr and wrapping
// NREQ-1 -> 0; one-hot grant plus encoded index.
module rr_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx,
  output logic            found
);

  logic [IDW:0]   sum;
  logic [IDW-1:0] idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    sum       = '0;
    idx       = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      // ptr < NREQ, so one conditional subtract is enough for the wrap
      sum = {1'b0, ptr} + (IDW+1)'(k);
      if (sum >= (IDW+1)'(NREQ)) sum = sum - (IDW+1)'(NREQ);
      idx = sum[IDW-1:0];
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/dp_share_sched.sv
// dp_share_sched: time-shares one combinational datapath among NREQ requesters.
// Optional macro DP_SCHED_PARITY_EN adds rsp_par (XOR parity of rsp_data).
module dp_share_sched
  import dp_sched_pkg::*;
#(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned OPW    = DEF_OPW,
  parameter int unsigned RESW   = DEF_RESW,
  parameter int unsigned SETTLE = 1,
  parameter int unsigned IDW    = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*OPW-1:0]  req_op,
  output logic [OPW-1:0]       dp_op,
  input  logic [RESW-1:0]      dp_res,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [RESW-1:0]      rsp_data,
  output logic                 busy
`ifdef DP_SCHED_PARITY_EN
  ,
  output logic                 rsp_par
`endif
);

  if (SETTLE < SETTLE_MIN || SETTLE > SETTLE_MAX) begin : g_settle_chk
    $error("dp_share_sched: SETTLE must be within 1..15");
  end
  if (NREQ < 2 || NREQ > 8) begin : g_nreq_chk
    $error("dp_share_sched: NREQ must be within 2..8");
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [IDW-1:0]   ptr_q, id_q, win_idx, next_ptr;
  logic [NREQ-1:0]  win_grant;
  logic             win_found;
  logic [OPW-1:0]   win_op;
  logic             accept, capture, rsp_fire;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req       (req_valid),
    .ptr       (ptr_q),
    .grant     (win_grant),
    .grant_idx (win_idx),
    .found     (win_found)
  );

  always_comb begin
    win_op = '0;
    for (int unsigned i = 0; i < NREQ; i++)
      if (win_grant[i]) win_op = req_op[i*OPW +: OPW];
  end

  assign next_ptr = (win_idx == IDW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
  assign busy     = (state_q != IDLE);

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    capture   = 1'b0;
    rsp_fire  = 1'b0;
    req_ready = '0;
    unique case (state_q)
      IDLE: if (!rst && win_found) begin
        req_ready = win_grant;
        accept    = 1'b1;
        state_d   = HOLD;
      end
      HOLD: if (cnt_q == '0) begin
        capture = 1'b1;
        state_d = RESP;
      end
      RESP: if (rsp_ready) begin
        rsp_fire = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ptr_q     <= '0;
      id_q      <= '0;
      dp_op     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        dp_op <= win_op;
        id_q  <= win_idx;
        cnt_q <= CNT_W'(SETTLE - 1);
        ptr_q <= next_ptr;
      end else if (state_q == HOLD && !capture) begin
        cnt_q <= cnt_q - 1'b1;
      end
      if (capture) begin
        rsp_data  <= dp_res;
        rsp_id    <= id_q;
        rsp_valid <= 1'b1;
      end else if (rsp_fire) begin
        rsp_valid <= 1'b0;
      end
    end
  end

`ifdef DP_SCHED_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst)          rsp_par <= 1'b0;
    else if (capture) rsp_par <= ^dp_res;
  end
`endif

  // A waiting requester must keep its request and operand until accepted.
  for (genvar i = 0; i < NREQ; i++) begin : g_hold
    a_req_hold: assert property (@(posedge clk) disable iff (rst)
      (req_valid[i] && !req_ready[i]) |=> (req_valid[i] && $stable(req_op[i*OPW +: OPW])));
  end

endmodule
